// File: rtl/sequence_gen_if.sv
// -----------------------------------------------------------------------------
// sequence_gen_if
//
// Purpose:
//   Bundles the control and serial-data signals of the sequence_gen serial
//   pattern transmitter.
//
// Modports:
//   master : the controlling logic. It drives start, abort and the operands.
//            It observes the serial stream and the status flags.
//   slave  : the sequence_gen block itself.
//
// Signals:
//   start         request, accepted only while the transmitter is idle
//   abort         synchronous cancel of an active transfer
//   pattern_in    PAT_W-bit pattern, sent MSB first
//   repeat_count  number of repetitions (0 = none)
//   gap_cycles    idle cycles between repetitions
//   sequence_out  serial data bit
//   valid_out     high while sequence_out carries a pattern bit
//   busy          high from start acceptance until done/abort
//   done          one-cycle completion pulse
//   bit_index     index of the pattern bit currently driven
// -----------------------------------------------------------------------------
interface sequence_gen_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
);
    localparam int IDX_W = $clog2(PAT_W);

    logic             start;
    logic             abort;
    logic [PAT_W-1:0] pattern_in;
    logic [CNT_W-1:0] repeat_count;
    logic [GAP_W-1:0] gap_cycles;

    logic             sequence_out;
    logic             valid_out;
    logic             busy;
    logic             done;
    logic [IDX_W-1:0] bit_index;

    modport master (
        output start, abort, pattern_in, repeat_count, gap_cycles,
        input  sequence_out, valid_out, busy, done, bit_index
    );

    modport slave (
        input  start, abort, pattern_in, repeat_count, gap_cycles,
        output sequence_out, valid_out, busy, done, bit_index
    );
endinterface

// File: rtl/sequence_gen.sv
// -----------------------------------------------------------------------------
// sequence_gen
//
// Purpose:
//   Serial pattern transmitter, the source side for the serial sequence
//   detector. It accepts a start request while idle and latches the pattern,
//   the repeat count and the gap length. It then shifts the pattern out MSB
//   first, one bit per clock. The pattern is repeated repeat_count times.
//   Repetitions are separated by gap_cycles idle cycles, or sent back-to-back
//   when gap_cycles is 0. The transfer ends with a one-cycle done pulse.
//
// Ports:
//   clock  system clock, rising edge
//   reset  asynchronous, active-high; clears all state immediately
//   bus    sequence_gen_if.slave
//          in : start, abort, pattern_in, repeat_count, gap_cycles
//          out: sequence_out, valid_out, busy, done, bit_index
//          All outputs are registered.
//
// Optional feature (compile-time macro SEQ_GEN_PARITY_EN):
//   When the macro is defined, each repetition is followed by one extra bit.
//   That bit is the even parity (XOR) of the latched pattern, sent with
//   valid_out=1 and bit_index=0. A repetition then takes PAT_W+1 cycles.
//   When the macro is undefined, no parity bit is sent.
//
// Timing (macro undefined, N>0 repetitions, G gap cycles):
//   busy stays high for 1 + N*PAT_W + (N-1)*G cycles. The first cycle after
//   acceptance is a lead cycle with busy=1 and valid_out=0. The MSB of the
//   first repetition follows on the next cycle.
// -----------------------------------------------------------------------------
module sequence_gen #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
) (
    input  logic           clock,
    input  logic           reset,
    sequence_gen_if.slave  bus
);
    localparam int IDX_W = $clog2(PAT_W);
    localparam logic [IDX_W-1:0] MSB_IDX = IDX_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0] ONE_REP = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    // The state register is aligned with the registered outputs. state_reg
    // always names the phase the outputs are showing in the current cycle.
    state_t           state_reg;

    // Operands latched at acceptance. They are never touched again until the
    // next acceptance, so input changes mid-transfer have no effect.
    logic [PAT_W-1:0] pattern_reg;
    logic [GAP_W-1:0] gap_len_reg;

    // remaining_reg counts the repetitions still owed, including the one
    // currently being shifted. It is therefore at least 1 inside SHIFT.
    logic [CNT_W-1:0] remaining_reg;

    // Counts the idle cycles left after the current GAP cycle.
    logic [GAP_W-1:0] gap_cnt_reg;

    logic             sequence_out_reg;
    logic             valid_out_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [IDX_W-1:0] bit_index_reg;

`ifdef SEQ_GEN_PARITY_EN
    // Set while the trailing parity bit of a repetition is on the line.
    logic             parity_phase_reg;
`endif

    // Index of the next lower pattern bit, used while stepping through SHIFT.
    logic [IDX_W-1:0] idx_dec;
    // High in the final cycle of a repetition, that is the last bit on the line.
    logic             rep_last;

    assign idx_dec = bit_index_reg - 1'b1;

`ifdef SEQ_GEN_PARITY_EN
    assign rep_last = parity_phase_reg;
`else
    assign rep_last = (bit_index_reg == '0);
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg        <= IDLE;
            pattern_reg      <= '0;
            gap_len_reg      <= '0;
            remaining_reg    <= '0;
            gap_cnt_reg      <= '0;
            sequence_out_reg <= 1'b0;
            valid_out_reg    <= 1'b0;
            busy_reg         <= 1'b0;
            done_reg         <= 1'b0;
            bit_index_reg    <= '0;
`ifdef SEQ_GEN_PARITY_EN
            parity_phase_reg <= 1'b0;
`endif
        end else begin
            // done is a single-cycle pulse. It is asserted only on the edge
            // that enters DONE.
            done_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    sequence_out_reg <= 1'b0;
                    valid_out_reg    <= 1'b0;
                    bit_index_reg    <= '0;
                    if (bus.start && !bus.abort) begin
                        pattern_reg   <= bus.pattern_in;
                        remaining_reg <= bus.repeat_count;
                        gap_len_reg   <= bus.gap_cycles;
                        // The lead cycle has the same outputs as a gap cycle
                        // (busy=1, valid_out=0). It is modelled as a GAP of
                        // length one. The zero-repeat case then drops
                        // straight into DONE from that cycle.
                        gap_cnt_reg   <= '0;
                        busy_reg      <= 1'b1;
                        state_reg     <= GAP;
                    end else begin
                        busy_reg      <= 1'b0;
                    end
                end

                GAP: begin
                    if (bus.abort) begin
                        state_reg        <= IDLE;
                        sequence_out_reg <= 1'b0;
                        valid_out_reg    <= 1'b0;
                        busy_reg         <= 1'b0;
                        bit_index_reg    <= '0;
                    end else if (gap_cnt_reg == '0) begin
                        if (remaining_reg == '0) begin
                            // Only reachable from the lead cycle when
                            // repeat_count was 0. No bits are sent.
                            state_reg        <= DONE;
                            sequence_out_reg <= 1'b0;
                            valid_out_reg    <= 1'b0;
                            busy_reg         <= 1'b0;
                            done_reg         <= 1'b1;
                            bit_index_reg    <= '0;
                        end else begin
                            state_reg        <= SHIFT;
                            sequence_out_reg <= pattern_reg[PAT_W-1];
                            valid_out_reg    <= 1'b1;
                            busy_reg         <= 1'b1;
                            bit_index_reg    <= MSB_IDX;
                        end
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg - 1'b1;
                    end
                end

                SHIFT: begin
                    if (bus.abort) begin
                        state_reg        <= IDLE;
                        sequence_out_reg <= 1'b0;
                        valid_out_reg    <= 1'b0;
                        busy_reg         <= 1'b0;
                        bit_index_reg    <= '0;
`ifdef SEQ_GEN_PARITY_EN
                        parity_phase_reg <= 1'b0;
`endif
                    end else if (!rep_last) begin
`ifdef SEQ_GEN_PARITY_EN
                        if (bit_index_reg == '0) begin
                            // The LSB has just been sent. Append the parity
                            // bit, keeping bit_index at 0.
                            parity_phase_reg <= 1'b1;
                            sequence_out_reg <= ^pattern_reg;
                        end else begin
                            bit_index_reg    <= idx_dec;
                            sequence_out_reg <= pattern_reg[idx_dec];
                        end
`else
                        bit_index_reg    <= idx_dec;
                        sequence_out_reg <= pattern_reg[idx_dec];
`endif
                    end else begin
`ifdef SEQ_GEN_PARITY_EN
                        parity_phase_reg <= 1'b0;
`endif
                        // Check for the final repetition before subtracting,
                        // so the count never wraps, even for a full-scale
                        // repeat_count.
                        if (remaining_reg == ONE_REP) begin
                            remaining_reg    <= '0;
                            state_reg        <= DONE;
                            sequence_out_reg <= 1'b0;
                            valid_out_reg    <= 1'b0;
                            busy_reg         <= 1'b0;
                            done_reg         <= 1'b1;
                            bit_index_reg    <= '0;
                        end else begin
                            remaining_reg <= remaining_reg - 1'b1;
                            if (gap_len_reg == '0) begin
                                // Back-to-back: the next MSB goes out on the
                                // very next cycle.
                                sequence_out_reg <= pattern_reg[PAT_W-1];
                                valid_out_reg    <= 1'b1;
                                bit_index_reg    <= MSB_IDX;
                            end else begin
                                state_reg        <= GAP;
                                gap_cnt_reg      <= gap_len_reg - 1'b1;
                                sequence_out_reg <= 1'b0;
                                valid_out_reg    <= 1'b0;
                                bit_index_reg    <= '0;
                            end
                        end
                    end
                end

                DONE: begin
                    // start and abort are both ignored here. The done pulse
                    // has already been issued on entry.
                    state_reg        <= IDLE;
                    sequence_out_reg <= 1'b0;
                    valid_out_reg    <= 1'b0;
                    busy_reg         <= 1'b0;
                    bit_index_reg    <= '0;
                end

                default: begin
                    state_reg        <= IDLE;
                    sequence_out_reg <= 1'b0;
                    valid_out_reg    <= 1'b0;
                    busy_reg         <= 1'b0;
                    bit_index_reg    <= '0;
                end
            endcase
        end
    end

    assign bus.sequence_out = sequence_out_reg;
    assign bus.valid_out    = valid_out_reg;
    assign bus.busy         = busy_reg;
    assign bus.done         = done_reg;
    assign bus.bit_index    = bit_index_reg;

endmodule

// File: tb/tb_sequence_gen.sv
// -----------------------------------------------------------------------------
// tb_sequence_gen
//
// Testbench for sequence_gen with PAT_W=4, CNT_W=8 and GAP_W=4.
//
// Table-driven part:
//   Each record holds the inputs applied during one cycle and the outputs
//   expected in that same cycle. Inputs are sampled at the rising edge that
//   ends the cycle, so their effect appears in the next record.
//
// Hand-written sequences:
//   - asynchronous reset mid-gap
//   - full-scale repeat count
// -----------------------------------------------------------------------------
module tb_sequence_gen;
    localparam int PAT_W = 4;
    localparam int CNT_W = 8;
    localparam int GAP_W = 4;
`ifdef SEQ_GEN_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic clock;
    logic reset;

    sequence_gen_if #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) seq_if ();

    sequence_gen #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (seq_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       start;
        logic       abort;
        logic [3:0] pat;
        logic [7:0] rpt;
        logic [3:0] gap;
        logic       e_seq;
        logic       e_valid;
        logic       e_busy;
        logic       e_done;
        logic [1:0] e_idx;
    } vec_t;

    vec_t vecs[$];

    int checks = 0;
    int errors = 0;

    // Sticky input values used by exp() when it builds a record.
    logic       cur_start = 1'b0;
    logic       cur_abort = 1'b0;
    logic [3:0] cur_pat   = 4'd0;
    logic [7:0] cur_rpt   = 8'd0;
    logic [3:0] cur_gap   = 4'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic drive(input logic s, input logic a, input logic [3:0] p,
                         input logic [7:0] r, input logic [3:0] g);
        cur_start = s; cur_abort = a; cur_pat = p; cur_rpt = r; cur_gap = g;
    endtask

    task automatic exp(input logic es, input logic ev, input logic eb,
                       input logic ed, input logic [1:0] ei);
        vec_t v;
        v.start = cur_start; v.abort = cur_abort; v.pat = cur_pat;
        v.rpt = cur_rpt; v.gap = cur_gap;
        v.e_seq = es; v.e_valid = ev; v.e_busy = eb; v.e_done = ed; v.e_idx = ei;
        vecs.push_back(v);
    endtask

    // One repetition: four pattern bits MSB first, plus the parity bit when
    // that feature is built in.
    task automatic rep(input logic b3, input logic b2, input logic b1,
                       input logic b0, input logic par);
        exp(b3, 1, 1, 0, 2'd3);
        exp(b2, 1, 1, 0, 2'd2);
        exp(b1, 1, 1, 0, 2'd1);
        exp(b0, 1, 1, 0, 2'd0);
`ifdef SEQ_GEN_PARITY_EN
        exp(par, 1, 1, 0, 2'd0);
`else
        if (par === 1'bx) exp(0, 0, 0, 0, 2'd0); // never true; par is always given
`endif
    endtask

    task automatic idle_row();
        exp(0, 0, 0, 0, 2'd0);
    endtask

    task automatic gap_row();
        exp(0, 0, 1, 0, 2'd0);
    endtask

    // Watchdog so the bench can never hang.
    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int busy_cnt;
        int valid_cnt;
        int ones_cnt;
        int done_cnt;
        int seen;

        // ---------------- reset state ----------------
        reset = 1'b1;
        seq_if.start = 1'b1;               // must be ignored while in reset
        seq_if.abort = 1'b0;
        seq_if.pattern_in = 4'b1011;
        seq_if.repeat_count = 8'd1;
        seq_if.gap_cycles = 4'd0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_outputs",
            {28'd0, seq_if.sequence_out, seq_if.valid_out, seq_if.busy, seq_if.done},
            32'd0);
        chk("reset_bit_index", {30'd0, seq_if.bit_index}, 32'd0);
        seq_if.start = 1'b0;
        reset = 1'b0;

        // ---------------- vector table ----------------
        // abort in IDLE blocks start
        drive(1, 1, 4'b1011, 8'd1, 4'd0); idle_row();
        drive(0, 0, 4'b1011, 8'd1, 4'd0); idle_row();
        idle_row();

        // pattern 1011, repeat 1, gap 0
        drive(1, 0, 4'b1011, 8'd1, 4'd0); idle_row();
        drive(0, 0, 4'b1011, 8'd1, 4'd0); gap_row();       // lead cycle
        rep(1, 0, 1, 1, 1);
        drive(1, 0, 4'b1011, 8'd1, 4'd0); exp(0, 0, 0, 1, 2'd0); // done; start ignored
        drive(0, 0, 4'b1011, 8'd1, 4'd0); idle_row();
        idle_row();

        // pattern 1011, repeat 3, gap 2; start held high and operands changed
        drive(1, 0, 4'b1011, 8'd3, 4'd2); idle_row();
        drive(1, 0, 4'b0100, 8'd0, 4'd0); gap_row();       // lead
        rep(1, 0, 1, 1, 1);
        gap_row(); gap_row();
        rep(1, 0, 1, 1, 1);
        gap_row(); gap_row();
        rep(1, 0, 1, 1, 1);
        exp(0, 0, 0, 1, 2'd0);                              // done, start still high
        drive(0, 0, 4'b0100, 8'd0, 4'd0); idle_row();
        idle_row();

        // repeat 0: busy one cycle, then done, no valid bits
        drive(1, 0, 4'b1011, 8'd0, 4'd3); idle_row();
        drive(0, 0, 4'b1011, 8'd0, 4'd3); gap_row();
        exp(0, 0, 0, 1, 2'd0);
        idle_row();

        // abort at 2nd bit of repetition 2, then a fresh 0110 transfer
        drive(1, 0, 4'b1011, 8'd2, 4'd0); idle_row();
        drive(0, 0, 4'b1011, 8'd2, 4'd0); gap_row();
        rep(1, 0, 1, 1, 1);
        exp(1, 1, 1, 0, 2'd3);
        drive(0, 1, 4'b1011, 8'd2, 4'd0); exp(0, 1, 1, 0, 2'd2);
        drive(1, 0, 4'b0110, 8'd1, 4'd0); idle_row();       // aborted: no done
        drive(0, 0, 4'b0110, 8'd1, 4'd0); gap_row();
        rep(0, 1, 1, 0, 0);
        exp(0, 0, 0, 1, 2'd0);
        idle_row();

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clock);
            #1;
            seq_if.start        = vecs[i].start;
            seq_if.abort        = vecs[i].abort;
            seq_if.pattern_in   = vecs[i].pat;
            seq_if.repeat_count = vecs[i].rpt;
            seq_if.gap_cycles   = vecs[i].gap;
            @(negedge clock);
            if ({seq_if.sequence_out, seq_if.valid_out, seq_if.busy, seq_if.done, seq_if.bit_index}
                !== {vecs[i].e_seq, vecs[i].e_valid, vecs[i].e_busy, vecs[i].e_done, vecs[i].e_idx}) begin
                errors++;
                $display("FAIL row%0d actual seq=%b valid=%b busy=%b done=%b idx=%0d required seq=%b valid=%b busy=%b done=%b idx=%0d",
                         i, seq_if.sequence_out, seq_if.valid_out, seq_if.busy, seq_if.done, seq_if.bit_index,
                         vecs[i].e_seq, vecs[i].e_valid, vecs[i].e_busy, vecs[i].e_done, vecs[i].e_idx);
            end
            checks++;
        end

        // ---------------- async reset in the middle of a gap ----------------
        @(posedge clock); #1;
        seq_if.start = 1'b1; seq_if.abort = 1'b0;
        seq_if.pattern_in = 4'b1011; seq_if.repeat_count = 8'd2; seq_if.gap_cycles = 4'd3;
        @(posedge clock); #1;
        seq_if.start = 1'b0;
        repeat (5 + PAR) @(posedge clock);      // lead + one repetition -> first gap cycle
        @(negedge clock);
        chk("in_gap_busy_valid", {30'd0, seq_if.busy, seq_if.valid_out}, 32'b10);
        #2 reset = 1'b1;
        #1;
        chk("reset_mid_gap",
            {28'd0, seq_if.sequence_out, seq_if.valid_out, seq_if.busy, seq_if.done}, 32'd0);
        #1 reset = 1'b0;
        done_cnt = 0;
        busy_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (seq_if.busy) busy_cnt++;
            if (seq_if.done) done_cnt++;
        end
        chk("after_reset_busy_cycles", busy_cnt, 0);
        chk("after_reset_done_pulses", done_cnt, 0);

        // ---------------- full-scale repeat count ----------------
        @(posedge clock); #1;
        seq_if.start = 1'b1;
        seq_if.pattern_in = 4'b1011; seq_if.repeat_count = 8'd255; seq_if.gap_cycles = 4'd0;
        @(posedge clock); #1;
        seq_if.start = 1'b0;
        busy_cnt = 0; valid_cnt = 0; ones_cnt = 0; done_cnt = 0; seen = 0;
        for (int c = 0; c < 3000 && seen == 0; c++) begin
            @(negedge clock);
            if (seq_if.busy) busy_cnt++;
            if (seq_if.valid_out) begin
                valid_cnt++;
                if (seq_if.sequence_out) ones_cnt++;
            end
            if (seq_if.done) begin
                done_cnt++;
                seen = 1;
            end
        end
        chk("max_rep_done_seen", seen, 1);
        chk("max_rep_busy_cycles", busy_cnt, 1 + 255 * (PAT_W + PAR));
        chk("max_rep_valid_cycles", valid_cnt, 255 * (PAT_W + PAR));
        chk("max_rep_ones", ones_cnt, 255 * (3 + PAR));
        @(negedge clock);
        chk("max_rep_back_to_idle",
            {28'd0, seq_if.sequence_out, seq_if.valid_out, seq_if.busy, seq_if.done}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
